// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: FSM encoding and sizing constants.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } pwm_state_t;

    localparam int PWM_DEFAULT_WIDTH = 16;
    localparam int FILTER_LEN        = 4;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for a single asynchronous bit; STAGES must be at least 2.
// Latency STAGES cycles, async active-low reset clears every stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an async input, reports on each closing rising edge.
// Latency SYNC_STAGES+1 cycles from pwm_in edge to valid (+3 with PWM_CAPTURE_FILTER_EN); no backpressure.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] period_count,
    output logic             level,
    output logic             valid
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic sync_s;
    logic s;
    logic s_d_q;
    logic rise;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pwm_in),
        .q     (sync_s)
    );

`ifdef PWM_CAPTURE_FILTER_EN
    // s follows the synchronised input only once it and the last three samples agree.
    logic [FILTER_LEN-2:0] hist_q;
    logic                  filt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[FILTER_LEN-3:0], sync_s};
            filt_q <= s;
        end
    end

    always_comb begin
        s = filt_q;
        if (sync_s && (&hist_q)) begin
            s = 1'b1;
        end else if (!sync_s && !(|hist_q)) begin
            s = 1'b0;
        end
    end
`else
    assign s = sync_s;
`endif

    assign rise = s & ~s_d_q;

    logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;

    always_comb begin
        per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
        hi_cnt_d  = (s && hi_cnt_q != CNT_MAX) ? hi_cnt_q + CNT_ONE : hi_cnt_q;
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end
    end

    pwm_state_t       state_q, state_d;
    logic             rpt;
    logic [WIDTH-1:0] rpt_hi, rpt_per;
    logic             rpt_lvl;

    // An edge wins over saturation, so a period of exactly CNT_MAX still reports normally.
    always_comb begin
        state_d = state_q;
        rpt     = 1'b0;
        rpt_hi  = hi_cnt_q;
        rpt_per = per_cnt_q;
        rpt_lvl = 1'b1;
        case (state_q)
            IDLE: begin
                if (rise) state_d = MEAS;
            end
            MEAS: begin
                if (rise) begin
                    rpt = 1'b1;
                end else if (per_cnt_q == CNT_MAX) begin
                    rpt     = 1'b1;
                    rpt_hi  = '0;
                    rpt_per = '0;
                    rpt_lvl = s;
                    state_d = STUCK;
                end
            end
            STUCK: begin
                if (rise) state_d = MEAS;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [WIDTH-1:0] high_count_q, period_count_q;
    logic             level_q, valid_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_d_q          <= 1'b0;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            state_q        <= IDLE;
            high_count_q   <= '0;
            period_count_q <= '0;
            level_q        <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            s_d_q     <= s;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            state_q   <= state_d;
            valid_q   <= rpt;
            if (rpt) begin
                high_count_q   <= rpt_hi;
                period_count_q <= rpt_per;
                level_q        <= rpt_lvl;
            end
        end
    end

    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign level        = level_q;
    assign valid        = valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a WIDTH=16 instance for PWM patterns and a WIDTH=8 instance for timeouts.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pwm_a = 1'b0;
    logic        pwm_b = 1'b0;
    logic [15:0] hi_a, per_a;
    logic [7:0]  hi_b, per_b;
    logic        lvl_a, lvl_b, vld_a, vld_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] hi;
        logic [15:0] per;
        logic        lvl;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (vld_a) qa.push_back('{cyc, hi_a, per_a, lvl_a});
        if (vld_b) qb.push_back('{cyc, {8'd0, hi_b}, {8'd0, per_b}, lvl_b});
    end

    pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut_a (
        .clock        (clock),
        .reset        (reset),
        .pwm_in       (pwm_a),
        .high_count   (hi_a),
        .period_count (per_a),
        .level        (lvl_a),
        .valid        (vld_a)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut_b (
        .clock        (clock),
        .reset        (reset),
        .pwm_in       (pwm_b),
        .high_count   (hi_b),
        .period_count (per_b),
        .level        (lvl_b),
        .valid        (vld_b)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);
        qa.delete();
        qb.delete();
    endtask

    task automatic pulse_a(input int h, input int l, output int t);
        pwm_a = 1'b1;
        t = cyc;
        wait_cyc(h);
        pwm_a = 1'b0;
        wait_cyc(l);
    endtask

    task automatic pulse_b(input int h, input int l, output int t);
        pwm_b = 1'b1;
        t = cyc;
        wait_cyc(h);
        pwm_b = 1'b0;
        wait_cyc(l);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++; if ({vld_a, lvl_a, hi_a, per_a} !== 34'd0) begin n_err++; $display("FAIL reset_a: got v=%b l=%b hi=%0d per=%0d, want all 0", vld_a, lvl_a, hi_a, per_a); end
        n_cmp++; if ({vld_b, lvl_b, hi_b, per_b} !== 18'd0) begin n_err++; $display("FAIL reset_b: got v=%b l=%b hi=%0d per=%0d, want all 0", vld_b, lvl_b, hi_b, per_b); end
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(40);
        n_cmp++; if (qa.size() + qb.size() != 0) begin n_err++; $display("FAIL reset_quiet: got %0d reports, want 0", qa.size() + qb.size()); end
    endtask

    task automatic test_duty64();
        int t, t1;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            pulse_a(64, 192, t);
            if (p == 1) t1 = t;
        end
        wait_cyc(10);
        n_cmp++; if (qa.size() != 4) begin n_err++; $display("FAIL duty64_count: got %0d, want 4", qa.size()); end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            n_cmp++;
            if (qa[i].hi !== 16'd64 || qa[i].per !== 16'd256 || qa[i].lvl !== 1'b1 || qa[i].cyc != t1 + LAT + 256 * i) begin
                n_err++;
                $display("FAIL duty64_rpt%0d: got hi=%0d per=%0d l=%b cyc=%0d, want 64/256/1 cyc=%0d",
                         i, qa[i].hi, qa[i].per, qa[i].lvl, qa[i].cyc, t1 + LAT + 256 * i);
            end
        end
    endtask

    task automatic test_duty_change();
        int t;
        logic [15:0] exp_hi [6] = '{16'd255, 16'd255, 16'd255, 16'd1, 16'd1, 16'd1};
        do_reset();
        for (int p = 0; p < 3; p++) pulse_a(255, 1, t);
        for (int p = 0; p < 3; p++) pulse_a(1, 255, t);
        pulse_a(10, 10, t);
        n_cmp++; if (qa.size() != 6) begin n_err++; $display("FAIL duty_chg_count: got %0d, want 6", qa.size()); end
        for (int i = 0; i < qa.size() && i < 6; i++) begin
            n_cmp++;
            if (qa[i].hi !== exp_hi[i] || qa[i].per !== 16'd256) begin
                n_err++;
                $display("FAIL duty_chg_rpt%0d: got hi=%0d per=%0d, want %0d/256", i, qa[i].hi, qa[i].per, exp_hi[i]);
            end
        end
    endtask

    task automatic test_timeout(input logic hold);
        int t0, t;
        do_reset();
        pwm_b = 1'b1;
        t0 = cyc;
        if (!hold) begin
            wait_cyc(10);
            pwm_b = 1'b0;
            wait_cyc(590);
        end else begin
            wait_cyc(600);
        end
        n_cmp++; if (qb.size() != 1) begin n_err++; $display("FAIL timeout%0b_count: got %0d, want 1", hold, qb.size()); end
        if (qb.size() > 0) begin
            n_cmp++;
            if (qb[0].hi !== 16'd0 || qb[0].per !== 16'd0 || qb[0].lvl !== hold || qb[0].cyc != t0 + LAT + 255) begin
                n_err++;
                $display("FAIL timeout%0b_rpt: got hi=%0d per=%0d l=%b cyc=%0d, want 0/0/%b cyc=%0d",
                         hold, qb[0].hi, qb[0].per, qb[0].lvl, qb[0].cyc, hold, t0 + LAT + 255);
            end
        end
        if (!hold) begin
            pulse_b(10, 90, t);
            pulse_b(5, 10, t);
            n_cmp++; if (qb.size() != 2) begin n_err++; $display("FAIL stuck_recover_count: got %0d, want 2", qb.size()); end
            if (qb.size() == 2) begin
                n_cmp++;
                if (qb[1].hi !== 16'd10 || qb[1].per !== 16'd100 || qb[1].lvl !== 1'b1) begin
                    n_err++;
                    $display("FAIL stuck_recover_rpt: got hi=%0d per=%0d l=%b, want 10/100/1", qb[1].hi, qb[1].per, qb[1].lvl);
                end
            end
        end
    endtask

    task automatic test_saturate_edge();
        int t, t2;
        do_reset();
        pulse_b(100, 155, t);
        pulse_b(5, 20, t2);
        n_cmp++; if (qb.size() != 1) begin n_err++; $display("FAIL sat_edge_count: got %0d, want 1", qb.size()); end
        if (qb.size() > 0) begin
            n_cmp++;
            if (qb[0].hi !== 16'd100 || qb[0].per !== 16'd255 || qb[0].lvl !== 1'b1 || qb[0].cyc != t2 + LAT) begin
                n_err++;
                $display("FAIL sat_edge_rpt: got hi=%0d per=%0d l=%b cyc=%0d, want 100/255/1 cyc=%0d",
                         qb[0].hi, qb[0].per, qb[0].lvl, qb[0].cyc, t2 + LAT);
            end
        end
    endtask

    task automatic test_mid_reset();
        int t;
        do_reset();
        pulse_a(20, 30, t);
        pulse_a(20, 30, t);
        pulse_a(20, 10, t);
        n_cmp++; if (per_a !== 16'd50 || hi_a !== 16'd20 || lvl_a !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got hi=%0d per=%0d l=%b, want 20/50/1", hi_a, per_a, lvl_a); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({vld_a, lvl_a, hi_a, per_a} !== 34'd0) begin n_err++; $display("FAIL midrst_clear: got v=%b l=%b hi=%0d per=%0d, want all 0", vld_a, lvl_a, hi_a, per_a); end
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);
        qa.delete();
        pulse_a(20, 30, t);
        n_cmp++; if (qa.size() != 0) begin n_err++; $display("FAIL midrst_first_edge: got %0d reports, want 0", qa.size()); end
        pulse_a(20, 10, t);
        n_cmp++; if (qa.size() != 1) begin n_err++; $display("FAIL midrst_second_edge: got %0d reports, want 1", qa.size()); end
        if (qa.size() == 1) begin
            n_cmp++;
            if (qa[0].per !== 16'd50 || qa[0].hi !== 16'd20 || qa[0].cyc != t + LAT) begin
                n_err++;
                $display("FAIL midrst_rpt: got hi=%0d per=%0d cyc=%0d, want 20/50 cyc=%0d", qa[0].hi, qa[0].per, qa[0].cyc, t + LAT);
            end
        end
    endtask

    task automatic test_glitch();
        int t;
        do_reset();
        pulse_a(30, 30, t);
        pulse_a(2, 38, t);
        pulse_a(30, 10, t);
`ifdef PWM_CAPTURE_FILTER_EN
        n_cmp++; if (qa.size() != 1) begin n_err++; $display("FAIL glitch_count: got %0d, want 1", qa.size()); end
        if (qa.size() == 1) begin
            n_cmp++;
            if (qa[0].per !== 16'd100 || qa[0].hi !== 16'd30) begin n_err++; $display("FAIL glitch_rpt: got hi=%0d per=%0d, want 30/100", qa[0].hi, qa[0].per); end
        end
`else
        n_cmp++; if (qa.size() != 2) begin n_err++; $display("FAIL glitch_count: got %0d, want 2", qa.size()); end
        if (qa.size() == 2) begin
            n_cmp++;
            if (qa[0].per !== 16'd60 || qa[0].hi !== 16'd30) begin n_err++; $display("FAIL glitch_split0: got hi=%0d per=%0d, want 30/60", qa[0].hi, qa[0].per); end
            n_cmp++;
            if (qa[1].per !== 16'd40 || qa[1].hi !== 16'd2) begin n_err++; $display("FAIL glitch_split1: got hi=%0d per=%0d, want 2/40", qa[1].hi, qa[1].per); end
        end
`endif
    endtask

    task automatic test_latency();
        int t;
        do_reset();
        pulse_a(5, 35, t);
        pwm_a = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clock);
            n_cmp++;
            if (vld_a !== (i == LAT)) begin
                n_err++;
                $display("FAIL latency_cyc%0d: got valid=%b, want %b", i, vld_a, (i == LAT));
            end
        end
        wait_cyc(5);
        pwm_a = 1'b0;
        wait_cyc(5);
    endtask

    initial begin
        test_reset();
        test_duty64();
        test_duty_change();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_saturate_edge();
        test_mid_reset();
        test_glitch();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
